// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory responder.
//   mem_size_e   : access-size encoding on the processor size port
//   resp_state_e : responder FSM state encoding
//   DEFAULT_WAIT_STATES : default added response latency in cycles
package dlx_mem_pkg;

    localparam int DEFAULT_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } resp_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering for the data-memory responder (purely combinational).
//   size, sign  : captured access size and load extension mode
//   offset      : byte offset within the word (addr[1:0])
//   wdata       : right-justified store data
//   rword       : word currently held at the addressed location
//   wword       : store data replicated onto every candidate lane
//   wmask       : per-lane write enable, bit 3 = most significant byte (offset 0)
//   load_data   : selected byte/halfword, right-justified and extended
//   align_fault : illegal size or misaligned halfword/word
module mem_lane_align
    import dlx_mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sign,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [3:0]  wmask,
    output logic [31:0] load_data,
    output logic        align_fault
);

    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Big-endian: offset 0 is bits 31:24, so the byte shift is (3 - offset) * 8,
    // and (3 - offset) on two bits is simply ~offset.
    assign byte_word = rword >> {~offset, 3'b000};
    assign half_word = rword >> {~offset[1], 4'b0000};
    assign byte_sel  = byte_word[7:0];
    assign half_sel  = half_word[15:0];

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        wword       = '0;
        wmask       = '0;
        load_data   = '0;
        align_fault = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wword     = {4{wdata[7:0]}};
                wmask     = 4'b1000 >> offset;
                load_data = {{24{sign & byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                wword       = {2{wdata[15:0]}};
                wmask       = offset[1] ? 4'b0011 : 4'b1100;
                load_data   = {{16{sign & half_sel[15]}}, half_sel};
                align_fault = offset[0];
            end
            SIZE_WORD: begin
                wword       = wdata;
                wmask       = 4'b1111;
                load_data   = rword;
                align_fault = |offset;
            end
            default: align_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory answering DLX load/store requests one at a time.
//   clk, reset : clock and asynchronous active-low reset
//   req, we    : request strobe and store (1) / load (0) select
//   size, sign : access size and load sign-extension select
//   addr       : byte address; wdata : right-justified store data
//   ready      : high while idle and able to accept a request
//   ack        : one-cycle completion pulse; rdata / err valid only with ack
module data_mem_responder
    import dlx_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    resp_state_e state_q, state_d;
    logic [3:0]  wait_cnt_q;

    // Request captured on acceptance; nothing downstream looks at the live inputs.
    logic        we_q;
    mem_size_e   size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic [31:0]      rword;
    logic [31:0]      wword;
    logic [3:0]       wmask;
    logic [31:0]      load_data;
    logic             align_fault;
    logic             fault;
    logic             mem_we;

    assign word_idx = addr_q[IDX_W+1:2];
    assign in_range = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
    assign rword    = in_range ? mem[word_idx] : '0;
    assign fault    = align_fault | ~in_range;

    mem_lane_align u_align (
        .size        (size_q),
        .sign        (sign_q),
        .offset      (addr_q[1:0]),
        .wdata       (wdata_q),
        .rword       (rword),
        .wword       (wword),
        .wmask       (wmask),
        .load_data   (load_data),
        .align_fault (align_fault)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            sign_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                we_q       <= we;
                size_q     <= mem_size_e'(size);
                sign_q     <= sign;
                addr_q     <= addr;
                wdata_q    <= wdata;
                // WAIT leaves when the counter reads zero, so preload WAIT_STATES-1.
                wait_cnt_q <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
            end else if (state_q == ST_WAIT && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        ack     = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) state_d = ST_RESP;
            end
            ST_RESP: begin
                ack     = 1'b1;
                err     = fault;
                rdata   = (!we_q && !fault) ? load_data : '0;
                mem_we  = we_q && !fault;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the array has no reset; contents survive reset and an asynchronous
    // reset forces state_q out of RESP, so an aborted store never commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[word_idx][b*8 +: 8] <= wword[b*8 +: 8];
            end
        end
    end

endmodule
